// File: rtl/dbram_inst.sv
// -----------------------------------------------------------------------------
// dbram_inst
// Simple-dual-port data SRAM behind the L1 data cache. It holds 2^ADDR_W
// words of DATA_W bits, has one write port with per-byte enables and one
// synchronous read port with a registered output. The cache places
// {way, set, word} in the address, but the RAM treats it as a flat index.
//
// Ports:
//   cpu_clock_i  in   1       sole clock, rising edge
//   cpu_reset_i  in   1       synchronous active-high reset (clears rd_data only)
//   rd_en        in   1       read request
//   rd_addr      in   ADDR_W  read word address
//   rd_data      out  DATA_W  registered read data, 1-cycle latency
//   wr_en        in   NB      per-byte write enable (bit i -> byte i)
//   wr_addr      in   ADDR_W  write word address
//   wr_data      in   DATA_W  write data
// -----------------------------------------------------------------------------
module dbram_inst #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                  cpu_clock_i,
  input  logic                  cpu_reset_i,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  input  logic [DATA_W/8-1:0]   wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  // Storage array. It is deliberately not reset so that it maps onto block RAM.
  logic [DATA_W-1:0] mem_r [DEPTH];

  logic [DATA_W-1:0] rd_data_r;

  // Write port: byte-lane masked write. It is independent of reset and of the read port.
  always_ff @(posedge cpu_clock_i) begin
    for (int b = 0; b < NB; b++) begin
      if (wr_en[b]) begin
        mem_r[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Read port: registered output. The non-blocking read of mem_r returns the
  // pre-write contents on an address collision, so the port is read-first.
  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      rd_data_r <= {DATA_W{1'b0}};
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end else begin
      rd_data_r <= rd_data_r;
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: tb/tb_dbram_inst.sv
// -----------------------------------------------------------------------------
// tb_dbram_inst
// Scoreboard bench for dbram_inst. Each cycle, the bench drives one request
// and pushes the rd_data value expected after that edge. The expected value
// comes from a bench-side memory model, the hold value or zero on reset. It
// pops the value and compares it one time unit after the edge. Fixed constants
// from the directed scenarios are also checked directly.
// -----------------------------------------------------------------------------
module tb_dbram_inst;

  logic        clk;
  logic        rst;
  logic        rd_en_s;
  logic [11:0] rd_addr_s;
  logic [31:0] rd_data_s;
  logic [3:0]  wr_en_s;
  logic [11:0] wr_addr_s;
  logic [31:0] wr_data_s;

  logic [31:0] model [4096];
  logic [31:0] hold_r;
  logic [31:0] exp_q [$];

  int check_cnt;
  int pass_cnt;

  dbram_inst #(.ADDR_W(12), .DATA_W(32)) dut (
    .cpu_clock_i (clk),
    .cpu_reset_i (rst),
    .rd_en       (rd_en_s),
    .rd_addr     (rd_addr_s),
    .rd_data     (rd_data_s),
    .wr_en       (wr_en_s),
    .wr_addr     (wr_addr_s),
    .wr_data     (wr_data_s)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  // One clock cycle: drive the inputs, predict the result, advance, and compare
  task automatic step(input string tag, input logic r, input logic re, input logic [11:0] ra,
                      input logic [3:0] we, input logic [11:0] wa, input logic [31:0] wd);
    logic [31:0] e;
    rst       = r;
    rd_en_s   = re;
    rd_addr_s = ra;
    wr_en_s   = we;
    wr_addr_s = wa;
    wr_data_s = wd;
    if (r)       e = 32'h0;
    else if (re) e = model[ra];
    else         e = hold_r;
    hold_r = e;
    exp_q.push_back(e);
    for (int b = 0; b < 4; b++) begin
      if (we[b]) model[wa][8*b +: 8] = wd[8*b +: 8];
    end
    @(posedge clk);
    #1;
    check_val(tag, rd_data_s, exp_q.pop_front());
  endtask

  initial begin
    check_cnt = 0;
    pass_cnt  = 0;
    hold_r    = 32'h0;
    for (int i = 0; i < 4096; i++) model[i] = 32'h0;
    rst = 1'b1; rd_en_s = 1'b0; rd_addr_s = 12'h0;
    wr_en_s = 4'h0; wr_addr_s = 12'h0; wr_data_s = 32'h0;

    // Reset and the initial read of an unwritten word
    step("reset", 1'b1, 1'b0, 12'h000, 4'h0, 12'h000, 32'h0);
    check_val("reset_zero", rd_data_s, 32'h0);
    step("rd_init", 1'b0, 1'b1, 12'h000, 4'h0, 12'h000, 32'h0);
    check_val("rd_init_zero", rd_data_s, 32'h0);

    // Full-word write, then a read, then the hold behaviour
    step("wr_full", 1'b0, 1'b0, 12'h000, 4'hF, 12'h7A5, 32'hDEADBEEF);
    step("rd_full", 1'b0, 1'b1, 12'h7A5, 4'h0, 12'h000, 32'h0);
    check_val("rd_full_k", rd_data_s, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      step("hold", 1'b0, 1'b0, 12'h000, 4'h0, 12'h000, 32'h0);
      check_val("hold_k", rd_data_s, 32'hDEADBEEF);
    end

    // Byte lanes
    step("lane_w0", 1'b0, 1'b0, 12'h000, 4'hF, 12'h010, 32'h11223344);
    step("lane_w1", 1'b0, 1'b0, 12'h000, 4'b0101, 12'h010, 32'hAABBCCDD);
    step("lane_r1", 1'b0, 1'b1, 12'h010, 4'h0, 12'h000, 32'h0);
    check_val("lane_r1_k", rd_data_s, 32'h11BB33DD);
    step("lane_w2", 1'b0, 1'b0, 12'h000, 4'b1000, 12'h010, 32'h99000000);
    step("lane_r2", 1'b0, 1'b1, 12'h010, 4'h0, 12'h000, 32'h0);
    check_val("lane_r2_k", rd_data_s, 32'h99BB33DD);

    // Read-first behaviour on an address collision
    step("col_w0", 1'b0, 1'b0, 12'h000, 4'hF, 12'h020, 32'h00000005);
    step("col_rw", 1'b0, 1'b1, 12'h020, 4'hF, 12'h020, 32'h00000009);
    check_val("col_old_k", rd_data_s, 32'h00000005);
    step("col_r", 1'b0, 1'b1, 12'h020, 4'h0, 12'h000, 32'h0);
    check_val("col_new_k", rd_data_s, 32'h00000009);

    // Line fill of way 1, set 17, followed by a back-to-back read-back
    for (int k = 0; k < 32; k++) begin
      step("fill_w", 1'b0, 1'b0, 12'h000, 4'hF, 12'hA20 + 12'(k), 32'(k) * 32'h01010101);
    end
    for (int k = 0; k < 32; k++) begin
      step("fill_r", 1'b0, 1'b1, 12'hA20 + 12'(k), 4'h0, 12'h000, 32'h0);
      check_val("fill_k", rd_data_s, 32'(k) * 32'h01010101);
    end
    for (int k = 0; k < 32; k++) begin
      step("way0", 1'b0, 1'b1, 12'h220 + 12'(k), 4'h0, 12'h000, 32'h0);
      check_val("way0_k", rd_data_s, 32'h0);
    end

    // Random mix in a small window, so that collisions and resets occur
    for (int n = 0; n < 300; n++) begin
      step("rand", ($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
           12'h300 + 12'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           12'h300 + 12'($urandom_range(0, 15)), $urandom);
    end

    // Reset during operation, with a write on the same edge
    step("mid_pre", 1'b0, 1'b1, 12'h7A5, 4'h0, 12'h000, 32'h0);
    check_val("mid_pre_k", rd_data_s, 32'hDEADBEEF);
    step("mid_rst", 1'b1, 1'b1, 12'h7A5, 4'hF, 12'h7A5, 32'hCAFEF00D);
    check_val("mid_rst_k", rd_data_s, 32'h0);
    step("mid_post", 1'b0, 1'b1, 12'h7A5, 4'h0, 12'h000, 32'h0);
    check_val("mid_post_k", rd_data_s, 32'hCAFEF00D);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
